// File: rtl/bp_fe_pkg.sv
// Shared front-end BHT definitions: counter type, sweep value, counter update rule, controller states.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package bp_fe_pkg;

  typedef logic [1:0] bp_fe_bht_cnt_t;

  // Weakly-not-taken: the value every entry holds after the power-on sweep
  localparam bp_fe_bht_cnt_t bht_init_cnt_gp = 2'b01;

  typedef enum logic {
    e_bht_init,
    e_bht_ready
  } bp_fe_bht_ctrl_state_e;

  // 2-bit saturating step toward the resolved direction; never wraps
  function automatic bp_fe_bht_cnt_t bht_cnt_next(input bp_fe_bht_cnt_t cnt, input logic taken);
    bp_fe_bht_cnt_t res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_fe_bht_upd_fifo.sv
// Circular FIFO of pending BHT updates {idx, cnt, taken}.
// Latency: entry enqueued at edge t is visible at the head in cycle t+1.
// Backpressure: ready_o low when full; no pass-through, so a full FIFO stays not-ready even while dequeuing.
module bp_fe_bht_upd_fifo
  import bp_fe_pkg::*;
#(
  parameter int idx_width_p = 9,
  parameter int els_p       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   clr_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [idx_width_p-1:0] idx_i,
  input  logic [1:0]             cnt_i,
  input  logic                   taken_i,
  output logic                   v_o,
  output logic [idx_width_p-1:0] idx_o,
  output logic [1:0]             cnt_o,
  output logic                   taken_o,
  input  logic                   yumi_i
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp:0] ptr_one_lp = (ptr_width_lp + 1)'(1);

  typedef struct packed {
    logic [idx_width_p-1:0] idx;
    bp_fe_bht_cnt_t         cnt;
    logic                   taken;
  } upd_entry_s;

  upd_entry_s            mem_r [els_p];
  upd_entry_s            head;
  logic [ptr_width_lp:0] wptr_r;
  logic [ptr_width_lp:0] rptr_r;
  logic                  enq;
  logic                  deq;
  logic                  full;

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign full    = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp])
                && (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
  assign v_o     = (wptr_r != rptr_r);
  assign ready_o = ~full;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  assign head    = mem_r[rptr_r[ptr_width_lp-1:0]];
  assign idx_o   = head.idx;
  assign cnt_o   = head.cnt;
  assign taken_o = head.taken;

  // Pointer bookkeeping; clear wins over any same-cycle enqueue or dequeue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else if (clr_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_one_lp;
      if (deq) rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  // Entry storage; contents are don't-care until the pointers cover them
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wptr_r[ptr_width_lp-1:0]] <= '{idx: idx_i, cnt: cnt_i, taken: taken_i};
    end
  end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// BHT sequencer: post-reset sweep to weakly-not-taken, then one queued counter update written per cycle.
// Latency: update written the cycle after acceptance (empty queue); prediction one cycle after r_v_i.
// Backpressure: upd_ready_o low during the sweep and while the update queue is full.
module bp_fe_bht_ctrl
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int upd_fifo_els_p  = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       upd_v_i,
  output logic                       upd_ready_o,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic [1:0]                 upd_cnt_i,
  input  logic                       upd_taken_i,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       tbl_r_v_o,
  output logic [bht_idx_width_p-1:0] tbl_r_idx_o,
  input  logic [1:0]                 tbl_r_cnt_i,
  output logic                       pred_v_o,
  output logic                       pred_taken_o,
  output logic [1:0]                 pred_cnt_o,
  output logic                       tbl_w_v_o,
  output logic [bht_idx_width_p-1:0] tbl_w_idx_o,
  output logic [1:0]                 tbl_w_cnt_o,
  output logic                       init_done_o
);

  localparam logic [bht_idx_width_p-1:0] last_idx_lp = '1;
  localparam logic [bht_idx_width_p-1:0] idx_one_lp  = bht_idx_width_p'(1);

  bp_fe_bht_ctrl_state_e        state_r;
  logic [bht_idx_width_p-1:0]   sweep_r;
  logic                         init_done_r;
  logic                         pred_v_r;

  logic                         fifo_ready;
  logic                         fifo_v;
  logic [bht_idx_width_p-1:0]   head_idx;
  logic [1:0]                   head_cnt;
  logic                         head_taken;

  // Sweep sequencer: one entry per cycle, hands over to update service after the last index
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_bht_init;
      sweep_r     <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        e_bht_init: begin
          sweep_r <= sweep_r + idx_one_lp;
          if (sweep_r == last_idx_lp) begin
            state_r     <= e_bht_ready;
            init_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= e_bht_ready;
        end
      endcase
    end
  end

  // Updates are neither accepted nor flushed until the table is initialized;
  // an update arriving with flush is dropped rather than queued behind it.
  bp_fe_bht_upd_fifo #(
    .idx_width_p(bht_idx_width_p),
    .els_p      (upd_fifo_els_p)
  ) upd_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clr_i    (flush_i & init_done_r),
    .v_i      (upd_v_i & init_done_r & ~flush_i),
    .ready_o  (fifo_ready),
    .idx_i    (upd_idx_i),
    .cnt_i    (upd_cnt_i),
    .taken_i  (upd_taken_i),
    .v_o      (fifo_v),
    .idx_o    (head_idx),
    .cnt_o    (head_cnt),
    .taken_o  (head_taken),
    .yumi_i   (fifo_v & init_done_r)
  );

  assign upd_ready_o = init_done_r & fifo_ready;
  assign init_done_o = init_done_r;

  // Single write port: sweep value during init, otherwise the updated head counter
  always_comb begin
    tbl_w_v_o   = 1'b0;
    tbl_w_idx_o = sweep_r;
    tbl_w_cnt_o = bht_init_cnt_gp;
    if (!init_done_r) begin
      tbl_w_v_o = 1'b1;
    end else if (fifo_v) begin
      tbl_w_v_o   = 1'b1;
      tbl_w_idx_o = head_idx;
      tbl_w_cnt_o = bht_cnt_next(head_cnt, head_taken);
    end
  end

  // Reads pass straight to the table once initialized; no write forwarding
  assign tbl_r_v_o   = r_v_i & init_done_r;
  assign tbl_r_idx_o = r_idx_i;

  // Track which cycle the table read data belongs to a real prediction
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pred_v_r <= 1'b0;
    end else begin
      pred_v_r <= r_v_i & init_done_r;
    end
  end

  assign pred_v_o     = pred_v_r;
  assign pred_cnt_o   = pred_v_r ? tbl_r_cnt_i : 2'b00;
  assign pred_taken_o = pred_cnt_o[1];

endmodule

// File: doc/bp_fe_bht_ctrl.md
# bp_fe_bht_ctrl

Sequencer and write-port scheduler for the front-end branch history table (2-bit saturating counters, 2^bht_idx_width_p entries, synchronous 1R1W storage). After reset it sweeps the whole table to the weakly-not-taken value, one entry per cycle. It then buffers branch-resolution updates from the backend in a small FIFO and computes each new counter value. It retires one table write per cycle and gates prediction reads until the table is initialized. It sits between the fetch PC generator, the branch-resolution path and the BHT storage.

## Interface
- bht_idx_width_p, 9, table index width; table depth N = 2^bht_idx_width_p
- upd_fifo_els_p, 2, update FIFO depth (power of two, ≥2)

- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all queued, unwritten updates
- upd_v_i  in  1  update request valid
- upd_ready_o  out  1  update FIFO can accept; transfer on upd_v_i & upd_ready_o
- upd_idx_i  in  bht_idx_width_p  index of resolved branch
- upd_cnt_i  in  2  counter value read at prediction time
- upd_taken_i  in  1  resolved direction
- r_v_i  in  1  fetch requests a prediction
- r_idx_i  in  bht_idx_width_p  prediction index
- tbl_r_v_o  out  1  table read enable
- tbl_r_idx_o  out  bht_idx_width_p  table read index
- tbl_r_cnt_i  in  2  table read data, valid one cycle after tbl_r_v_o
- pred_v_o  out  1  prediction valid
- pred_taken_o  out  1  predicted direction
- pred_cnt_o  out  2  raw counter, returned later as upd_cnt_i
- tbl_w_v_o  out  1  table write enable
- tbl_w_idx_o  out  bht_idx_width_p  write index
- tbl_w_cnt_o  out  2  write data
- init_done_o  out  1  sweep complete

## Operation
- States: INIT, READY. Reset enters INIT with sweep counter = 0.
- INIT: tbl_w_v_o=1, tbl_w_idx_o=sweep counter, tbl_w_cnt_o=2'b01. The sweep counter increments every cycle. After writing index N-1 the block moves to READY. upd_ready_o=0. tbl_r_v_o=0 and pred_v_o=0 regardless of r_v_i. flush_i has no effect on the sweep.
- READY: upd_ready_o = FIFO not full. Enqueues occur only on upd_v_i & upd_ready_o. There is no pass-through: a full FIFO stays not-ready even when it is dequeuing in the same cycle.
- Write scheduling in READY: if the FIFO is non-empty, drive the head entry. tbl_w_v_o=1, tbl_w_idx_o=head idx, tbl_w_cnt_o=next(head cnt, head taken). The head is dequeued in the same cycle.
- Counter update, taken: 00→01, 01→10, 10→11, 11→11. Not taken: 11→10, 10→01, 01→00, 00→00. Arithmetic is 2-bit and saturating; it never wraps.
- Reads in READY: tbl_r_v_o=r_v_i and tbl_r_idx_o=r_idx_i (combinational pass). pred_v_o is r_v_i registered. pred_cnt_o=tbl_r_cnt_i and pred_taken_o=tbl_r_cnt_i[1].
- Read and write to the same index in the same cycle return the old value. No forwarding is performed.
- flush_i in READY empties the FIFO at the next edge. A write of the head in the flush cycle still occurs. Enqueue in the flush cycle is dropped.
- upd_v_i & flush_i in the same cycle: the update is dropped, and upd_ready_o behaves normally.

## Timing
- Reset values: upd_ready_o=0, pred_v_o=0, pred_taken_o=0, pred_cnt_o=0, init_done_o=0, tbl_r_v_o=0.
- Reset values, write port: tbl_w_v_o=1 with idx 0 and data 2'b01 as soon as reset_n_i deasserts.
- The sweep takes exactly N cycles, with writes at cycles 0..N-1 after the first edge following deassertion.
- init_done_o and upd_ready_o rise in cycle N and stay high; init_done_o remains 1 until the next reset.
- Update latency: accepted at edge t, written at cycle t+1 when the FIFO was empty. Throughput is one write per cycle.
- Prediction latency: r_v_i at cycle t gives pred_v_o at t+1.
- Reset mid-operation: asynchronous clear of FIFO, state and pred_v_o. The sweep restarts at index 0.

## Structure
- bp_fe_pkg holds the following shared definitions:
  - typedef bp_fe_bht_cnt_t (2 bits)
  - localparam bht_init_cnt_gp = 2'b01
  - function bht_cnt_next(cnt, taken)
  - enum bp_fe_bht_ctrl_state_e {e_bht_init, e_bht_ready}
- Sub-module bp_fe_bht_upd_fifo: parameterized circular FIFO with an entry of {idx, cnt, taken}. It provides valid/ready enqueue, head-valid/yumi dequeue, and a synchronous clear. Asynchronous active-low reset clears the pointers.

## Test plan
- Reset, W=4: tbl_w_v_o is high for 16 cycles with idx 0..15 and data 01. init_done_o rises in cycle 16. pred_v_o stays 0 while r_v_i=1 during INIT.
- Single update idx=5, cnt=01, taken=1: one write next cycle with idx 5 and data 10. Saturation checks: cnt=11, taken → 11; cnt=00, not taken → 00.
- Back-to-back updates at 3 per burst with depth 2: upd_ready_o drops when full. All accepted updates are written in order and none are lost or duplicated.
- Flush with 2 queued entries: the head is written in the flush cycle, the second is never written, and an upd_v_i in the same cycle is dropped.
- Read idx=7 with tbl_r_cnt_i=10: pred_v_o=1, pred_taken_o=1 and pred_cnt_o=10 one cycle later.
- Assert reset_n_i mid-burst with FIFO non-empty: outputs clear immediately and the sweep restarts at idx 0. Old entries are never written.
